// File: rtl/riscv_pkg.sv
// Shared types and constants for the multicycle RV32I controller.
// Holds the FSM state encoding, opcodes and datapath mux selects.
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } ctrl_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bundle between the multicycle controller and the datapath.
// master: controller (drives controls); slave: datapath (drives status).
interface multicycle_ctrl_fsm_if;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       illegal_op;
    logic [3:0] state_o;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write,
        output result_src, alu_src_a, alu_src_b, alu_op,
        output reg_write, illegal_op, state_o
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write,
        input  result_src, alu_src_a, alu_src_b, alu_op,
        input  reg_write, illegal_op, state_o
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_out_decode.sv
// ctrl_out_decode: combinational map from state and rdy to datapath controls.
// Ports: state, rdy, rst, zero in; pc_write..reg_write out.
module ctrl_out_decode
    import riscv_pkg::*;
(
    input  ctrl_state_t state,
    input  logic        rdy,
    input  logic        rst,
    input  logic        zero,
    output logic        pc_write,
    output logic        adr_src,
    output logic        mem_write,
    output logic        ir_write,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write
);

    logic pc_update;
    logic branch;

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        unique case (state)
            S_FETCH: begin
                ir_write   = rdy;
                pc_update  = rdy;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
            end
            // ALUOut <= OldPC + imm, the branch target
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_write  = 1'b1;
            end
            // strobe held through every wait cycle
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            // PC <= ALUOut (target); ALUResult = OldPC + 4 for the link
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
        // no architectural write may escape while reset is high
        if (rst) begin
            pc_update = 1'b0;
            branch    = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
        end
    end

    assign pc_write = pc_update | (branch & zero);

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle RV32I core: state register + next state.
// Ports: clk, rst (async, active high), bus (controller side of the bundle).
module multicycle_ctrl_fsm
    import riscv_pkg::*;
#(
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    multicycle_ctrl_fsm_if.master bus
);

    ctrl_state_t state_q;
    ctrl_state_t state_d;
    logic        rdy;
    logic        illegal;

    assign rdy = bus.mem_ready | ~MEM_WAIT_EN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        illegal = 1'b0;
        unique case (state_q)
            S_FETCH:    state_d = rdy ? S_DECODE : S_FETCH;
            S_DECODE: begin
                unique case (bus.opcode)
                    OP_LOAD,
                    OP_STORE:  state_d = S_MEMADR;
                    OP_RTYPE:  state_d = S_EXECR;
                    OP_ITYPE:  state_d = S_EXECI;
                    OP_BRANCH: state_d = S_BEQ;
                    OP_JAL:    state_d = S_JAL;
                    default:   illegal = 1'b1;
                endcase
            end
            // only loads and stores reach here; bit 5 tells them apart
            S_MEMADR:   state_d = bus.opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = rdy ? S_MEMWB : S_MEMREAD;
            S_MEMWRITE: state_d = rdy ? S_FETCH : S_MEMWRITE;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            // MEMWB, ALUWB, BEQ and unused codes return to fetch
            default:    state_d = S_FETCH;
        endcase
    end

    assign bus.illegal_op = illegal;
    assign bus.state_o    = state_q;

    ctrl_out_decode u_out (
        .state      (state_q),
        .rdy        (rdy),
        .rst        (rst),
        .zero       (bus.zero),
        .pc_write   (bus.pc_write),
        .adr_src    (bus.adr_src),
        .mem_write  (bus.mem_write),
        .ir_write   (bus.ir_write),
        .result_src (bus.result_src),
        .alu_src_a  (bus.alu_src_a),
        .alu_src_b  (bus.alu_src_b),
        .alu_op     (bus.alu_op),
        .reg_write  (bus.reg_write)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized scoreboard bench for multicycle_ctrl_fsm.
// dut0 waits on mem_ready, dut1 ignores it; both checked against one model.
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus0 ();
    multicycle_ctrl_fsm_if bus1 ();

    multicycle_ctrl_fsm #(.MEM_WAIT_EN(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.master)
    );

    multicycle_ctrl_fsm #(.MEM_WAIT_EN(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.master)
    );

    // {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
    //  alu_src_b, alu_op, reg_write, illegal_op, state}
    logic [17:0] act0, act1;
    assign act0 = {bus0.pc_write, bus0.adr_src, bus0.mem_write,
                   bus0.ir_write, bus0.result_src, bus0.alu_src_a,
                   bus0.alu_src_b, bus0.alu_op, bus0.reg_write,
                   bus0.illegal_op, bus0.state_o};
    assign act1 = {bus1.pc_write, bus1.adr_src, bus1.mem_write,
                   bus1.ir_write, bus1.result_src, bus1.alu_src_a,
                   bus1.alu_src_b, bus1.alu_op, bus1.reg_write,
                   bus1.illegal_op, bus1.state_o};

    // Per-state mux selects, straight from the state table
    localparam logic [1:0] RES_T [11] =
        '{2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00,
          2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    localparam logic [1:0] A_T [11] =
        '{2'b00, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00,
          2'b10, 2'b10, 2'b00, 2'b10, 2'b01};
    localparam logic [1:0] B_T [11] =
        '{2'b10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00,
          2'b00, 2'b01, 2'b00, 2'b00, 2'b10};
    localparam logic [1:0] OP_T [11] =
        '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
          2'b10, 2'b10, 2'b00, 2'b01, 2'b00};

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;

    logic [17:0] q0[$];
    logic [17:0] q1[$];

    // Model state: current state number and the states still to visit
    int          cur  [2];
    logic [23:0] path [2];
    logic [6:0]  op   [2];
    bit          zr   [2];
    bit          mr   [2];

    // Post-decode route of each instruction, lowest nibble first
    function automatic logic [23:0] path_of(input logic [6:0] o);
        case (o)
            7'b0000011: return 24'h000432;
            7'b0100011: return 24'h000052;
            7'b0110011: return 24'h000086;
            7'b0010011: return 24'h000087;
            7'b1100011: return 24'h000009;
            7'b1101111: return 24'h00008A;
            default:    return 24'h000000;
        endcase
    endfunction

    function automatic logic [17:0] expect_out(input int s_in, input bit r,
                                               input bit rdy, input bit z,
                                               input logic [6:0] o);
        int   s;
        logic pcw, adr, mw, irw, rw, ill;
        s   = r ? 0 : s_in;
        adr = (s == 3) || (s == 5);
        mw  = (s == 5);
        rw  = (s == 4) || (s == 8);
        irw = (s == 0) && rdy;
        pcw = ((s == 0) && rdy) || (s == 10) || ((s == 9) && z);
        ill = (s == 1) && (path_of(o) == 24'h0);
        if (r) begin
            pcw = 1'b0;
            irw = 1'b0;
            mw  = 1'b0;
            rw  = 1'b0;
        end
        return {pcw, adr, mw, irw, RES_T[s], A_T[s], B_T[s], OP_T[s],
                rw, ill, 4'(s)};
    endfunction

    task automatic model_step(input int d, input bit r, input bit rdy);
        if (r) begin
            cur[d]  = 0;
            path[d] = '0;
        end else if ((cur[d] == 0 || cur[d] == 3 || cur[d] == 5) && !rdy) begin
            cur[d] = cur[d];
        end else if (cur[d] == 0) begin
            cur[d] = 1;
        end else begin
            if (cur[d] == 1) path[d] = path_of(op[d]);
            cur[d]  = int'(path[d][3:0]);
            path[d] = path[d] >> 4;
        end
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 9))
            0, 8:    return 7'b0000011;
            1, 9:    return 7'b0100011;
            2:       return 7'b0110011;
            3:       return 7'b0010011;
            4:       return 7'b1100011;
            5:       return 7'b1101111;
            6:       return 7'b1110011;
            default: return 7'($urandom_range(0, 127));
        endcase
    endfunction

    // Monitor: every cycle the DUTs present a full control word
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                vectors++;
                if (act0 !== e) begin
                    miscompares++;
                    $display("FAIL dut0 ctrl @%0t: got %h want %h",
                             $time, act0, e);
                end
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                vectors++;
                if (act1 !== e) begin
                    miscompares++;
                    $display("FAIL dut1 ctrl @%0t: got %h want %h",
                             $time, act1, e);
                end
            end
        end
    end

    // Stimulus + model
    initial begin
        for (int d = 0; d < 2; d++) begin
            cur[d]  = 0;
            path[d] = '0;
            op[d]   = 7'b0000011;
            zr[d]   = 1'b0;
            mr[d]   = 1'b1;
        end
        bus0.opcode = op[0]; bus0.zero = 1'b0; bus0.mem_ready = 1'b1;
        bus1.opcode = op[1]; bus1.zero = 1'b0; bus1.mem_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            rst = (c < 3) || ($urandom_range(0, 59) == 0);
            for (int d = 0; d < 2; d++) begin
                if (cur[d] == 0) op[d] = pick_op();
                zr[d] = 1'($urandom_range(0, 1));
                mr[d] = ($urandom_range(0, 2) != 0);
            end
            bus0.opcode = op[0]; bus0.zero = zr[0]; bus0.mem_ready = mr[0];
            bus1.opcode = op[1]; bus1.zero = zr[1]; bus1.mem_ready = mr[1];
            q0.push_back(expect_out(cur[0], rst, mr[0], zr[0], op[0]));
            q1.push_back(expect_out(cur[1], rst, 1'b1, zr[1], op[1]));
            model_step(0, rst, mr[0]);
            model_step(1, rst, 1'b1);
        end
        @(negedge clk);
        @(negedge clk);
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending want 0/0",
                     q0.size(), q1.size());
        end
        if (vectors == 0) begin
            miscompares++;
            $display("FAIL activity: got 0 vectors want >0");
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
